// File: rtl/gps_code_pkg.sv
// Shared types, constants and Gold-code feedback helpers for the GPS L1 C/A
// code NCO and PRN generator.
package gps_code_pkg;

    typedef logic [31:0] phase_t;
    typedef logic [9:0]  chip_idx_t;
    typedef logic [10:1] lfsr_t;

    localparam int unsigned CA_CHIPS           = 1023;
    localparam phase_t      NOMINAL_FCW_16M368 = 32'h1000_0000;
    localparam lfsr_t       LFSR_INIT          = 10'h3ff;

    // G1 characteristic polynomial 1 + x^3 + x^10
    function automatic logic g1_feedback(input lfsr_t s);
        return s[3] ^ s[10];
    endfunction

    // G2 characteristic polynomial 1 + x^2 + x^3 + x^6 + x^8 + x^9 + x^10
    function automatic logic g2_feedback(input lfsr_t s);
        return ^{s[2], s[3], s[6], s[8], s[9], s[10]};
    endfunction

endpackage

// File: rtl/ca_code_lfsr.sv
// G1/G2 Gold-code register pair; the chip bit is the G1 output combined with
// the phase-selected G2 taps of the current state.
module ca_code_lfsr
    import gps_code_pkg::*;
#(
    parameter int unsigned G2_TAP_A = 2,
    parameter int unsigned G2_TAP_B = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic step,
    input  logic reload,
    output logic chip
);

    lfsr_t g1_r;
    lfsr_t g2_r;

    // Shift both registers toward bit 10, or restart them at the code epoch
    always_ff @(posedge clk) begin
        if (rst) begin
            g1_r <= LFSR_INIT;
            g2_r <= LFSR_INIT;
        end else if (reload) begin
            g1_r <= LFSR_INIT;
            g2_r <= LFSR_INIT;
        end else if (step) begin
            g1_r <= {g1_r[9:1], g1_feedback(g1_r)};
            g2_r <= {g2_r[9:1], g2_feedback(g2_r)};
        end else begin
            g1_r <= g1_r;
            g2_r <= g2_r;
        end
    end

    assign chip = g1_r[10] ^ g2_r[G2_TAP_A] ^ g2_r[G2_TAP_B];

endmodule

// File: rtl/code_nco_prn_gen.sv
// Code-tracking NCO driving a C/A PRN generator, with an early/prompt/late
// delay line feeding the DLL correlators.
module code_nco_prn_gen
    import gps_code_pkg::*;
#(
    parameter int unsigned             PHASE_W     = 32,
    parameter logic [PHASE_W-1:0]      NOMINAL_FCW = NOMINAL_FCW_16M368,
    parameter int unsigned             CHIPS       = CA_CHIPS,
    parameter int unsigned             G2_TAP_A    = 2,
    parameter int unsigned             G2_TAP_B    = 6,
    parameter int unsigned             EL_SPACING  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               corr_valid,
    input  logic [PHASE_W-1:0] correction,
    output logic               early,
    output logic               prompt,
    output logic               late,
    output logic [9:0]         chip_idx,
    output logic               epoch,
    output logic [PHASE_W-1:0] code_phase
);

    localparam int unsigned DL_W = 2 * EL_SPACING;
    localparam chip_idx_t   LAST_CHIP = chip_idx_t'(CHIPS - 1);
    // Upper clamp keeps fcw below 2^(PHASE_W-1), so at most one carry per sample
    localparam logic signed [PHASE_W:0] FCW_MIN = {{PHASE_W{1'b0}}, 1'b1};
    localparam logic signed [PHASE_W:0] FCW_MAX = {2'b00, {(PHASE_W-1){1'b1}}};

    logic [PHASE_W-1:0]        phase_r;
    logic [PHASE_W-1:0]        fcw_r;
    chip_idx_t                 chip_idx_r;
    logic                      early_r;
    logic                      epoch_r;
    logic [DL_W:1]             dl_r;

    logic [PHASE_W:0]          acc_s;
    logic                      carry_s;
    logic                      wrap_s;
    logic                      step_s;
    logic                      reload_s;
    logic                      chip_s;
    logic signed [PHASE_W:0]   fcw_sum_s;
    logic [PHASE_W-1:0]        fcw_next_s;

    // Phase accumulation and chip-boundary decode
    always_comb begin
        acc_s    = {1'b0, phase_r} + {1'b0, fcw_r};
        carry_s  = acc_s[PHASE_W];
        wrap_s   = (chip_idx_r == LAST_CHIP);
        step_s   = enable & carry_s & ~wrap_s;
        reload_s = enable & carry_s & wrap_s;
    end

    // Nominal plus signed correction, clamped to the legal fcw range
    always_comb begin
        fcw_sum_s = $signed({1'b0, NOMINAL_FCW}) + $signed({correction[PHASE_W-1], correction});
        if (fcw_sum_s < FCW_MIN) begin
            fcw_next_s = FCW_MIN[PHASE_W-1:0];
        end else if (fcw_sum_s > FCW_MAX) begin
            fcw_next_s = FCW_MAX[PHASE_W-1:0];
        end else begin
            fcw_next_s = fcw_sum_s[PHASE_W-1:0];
        end
    end

    ca_code_lfsr #(
        .G2_TAP_A (G2_TAP_A),
        .G2_TAP_B (G2_TAP_B)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .step   (step_s),
        .reload (reload_s),
        .chip   (chip_s)
    );

    // NCO, chip counter, output registers and early/prompt/late delay line
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r    <= {PHASE_W{1'b0}};
            fcw_r      <= NOMINAL_FCW;
            chip_idx_r <= 10'd0;
            early_r    <= 1'b0;
            epoch_r    <= 1'b0;
            dl_r       <= {DL_W{1'b0}};
        end else begin
            if (corr_valid) begin
                fcw_r <= fcw_next_s;
            end else begin
                fcw_r <= fcw_r;
            end
            if (enable) begin
                phase_r <= acc_s[PHASE_W-1:0];
                early_r <= chip_s;
                dl_r    <= {dl_r[DL_W-1:1], early_r};
                epoch_r <= reload_s;
                if (carry_s) begin
                    chip_idx_r <= wrap_s ? 10'd0 : chip_idx_r + 10'd1;
                end else begin
                    chip_idx_r <= chip_idx_r;
                end
            end else begin
                epoch_r <= 1'b0;
            end
        end
    end

    assign early      = early_r;
    assign prompt     = dl_r[EL_SPACING];
    assign late       = dl_r[DL_W];
    assign chip_idx   = chip_idx_r;
    assign epoch      = epoch_r;
    assign code_phase = phase_r;

endmodule

// File: tb/tb_code_nco_prn_gen.sv
// Directed bench for code_nco_prn_gen: PRN1 chip order, epoch period, delay
// taps, enable gating, fcw correction/clamping and mid-run reset.
module tb_code_nco_prn_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        corr_valid;
    logic [31:0] correction;
    logic        early;
    logic        prompt;
    logic        late;
    logic [9:0]  chip_idx;
    logic        epoch;
    logic [31:0] code_phase;

    int n_cmp = 0;
    int n_err = 0;
    int n_en  = 0;
    logic [9:0] prn1_head = 10'b1100100000;

    code_nco_prn_gen dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .corr_valid (corr_valid),
        .correction (correction),
        .early      (early),
        .prompt     (prompt),
        .late       (late),
        .chip_idx   (chip_idx),
        .epoch      (epoch),
        .code_phase (code_phase)
    );

    always #5 clk = ~clk;

    // Expected early after the m-th enabled edge at nominal rate (first 10 chips of each period)
    function automatic logic exp_early(input int m);
        int k;
        if (m < 1) return 1'b0;
        k = ((m - 1) / 16) % 1023;
        if (k > 9) return 1'bx;
        return prn1_head[9 - k];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_en();
        enable = 1'b1;
        tick();
        n_en++;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; corr_valid = 1'b0; correction = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        n_en = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; corr_valid = 1'b1; correction = 32'h1234_5678;
        tick();
        tick();
        n_cmp++; if ({early, prompt, late, epoch} !== 4'b0000) begin n_err++; $display("FAIL reset_outs: got %b expected 0000", {early, prompt, late, epoch}); end
        n_cmp++; if (chip_idx !== 10'd0) begin n_err++; $display("FAIL reset_chip_idx: got %0d expected 0", chip_idx); end
        n_cmp++; if (code_phase !== 32'd0) begin n_err++; $display("FAIL reset_phase: got %h expected 0", code_phase); end
        rst = 1'b0; corr_valid = 1'b0; correction = 32'd0; enable = 1'b0;
        tick();
        n_cmp++; if (code_phase !== 32'd0) begin n_err++; $display("FAIL reset_fcw_held: got %h expected 0", code_phase); end
        n_en = 0;
    endtask

    task automatic test_prn1(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step_en();
            n_cmp++; if (early !== exp_early(n_en)) begin n_err++; $display("FAIL prn1_early n=%0d: got %b expected %b", n_en, early, exp_early(n_en)); end
            n_cmp++; if (prompt !== exp_early(n_en - 8)) begin n_err++; $display("FAIL prn1_prompt n=%0d: got %b expected %b", n_en, prompt, exp_early(n_en - 8)); end
            n_cmp++; if (late !== exp_early(n_en - 16)) begin n_err++; $display("FAIL prn1_late n=%0d: got %b expected %b", n_en, late, exp_early(n_en - 16)); end
            n_cmp++; if (chip_idx !== 10'(n_en / 16)) begin n_err++; $display("FAIL prn1_chip_idx n=%0d: got %0d expected %0d", n_en, chip_idx, n_en / 16); end
            n_cmp++; if (code_phase !== (32'(n_en) << 28)) begin n_err++; $display("FAIL prn1_phase n=%0d: got %h expected %h", n_en, code_phase, 32'(n_en) << 28); end
        end
    endtask

    task automatic test_freeze();
        enable = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            n_cmp++; if (code_phase !== (32'(n_en) << 28)) begin n_err++; $display("FAIL freeze_phase: got %h expected %h", code_phase, 32'(n_en) << 28); end
            n_cmp++; if (chip_idx !== 10'(n_en / 16)) begin n_err++; $display("FAIL freeze_chip_idx: got %0d expected %0d", chip_idx, n_en / 16); end
            n_cmp++; if ({early, prompt, late} !== {exp_early(n_en), exp_early(n_en - 8), exp_early(n_en - 16)}) begin
                n_err++; $display("FAIL freeze_epl: got %b expected %b", {early, prompt, late}, {exp_early(n_en), exp_early(n_en - 8), exp_early(n_en - 16)});
            end
            n_cmp++; if (epoch !== 1'b0) begin n_err++; $display("FAIL freeze_epoch: got %b expected 0", epoch); end
        end
        step_en();
        n_cmp++; if (code_phase !== (32'(n_en) << 28)) begin n_err++; $display("FAIL freeze_resume: got %h expected %h", code_phase, 32'(n_en) << 28); end
    endtask

    task automatic test_epoch();
        int pulses = 0;
        while (n_en < 2 * 16368 + 170) begin
            step_en();
            if (epoch === 1'b1) pulses++;
            n_cmp++; if (epoch !== ((n_en % 16368) == 0)) begin n_err++; $display("FAIL epoch_pulse n=%0d: got %b expected %b", n_en, epoch, (n_en % 16368) == 0); end
            if ((n_en % 16368) == 0) begin
                n_cmp++; if (chip_idx !== 10'd0) begin n_err++; $display("FAIL epoch_wrap n=%0d: got %0d expected 0", n_en, chip_idx); end
            end
            if ((n_en % 16368) == 16367) begin
                n_cmp++; if (chip_idx !== 10'd1022) begin n_err++; $display("FAIL epoch_last n=%0d: got %0d expected 1022", n_en, chip_idx); end
            end
            if (n_en > 16368 && ((n_en - 1) % 16) == 0 && (((n_en - 1) / 16) % 1023) < 10) begin
                n_cmp++; if (early !== exp_early(n_en)) begin n_err++; $display("FAIL epoch_repeat n=%0d: got %b expected %b", n_en, early, exp_early(n_en)); end
            end
        end
        n_cmp++; if (pulses !== 2) begin n_err++; $display("FAIL epoch_count: got %0d expected 2", pulses); end
    endtask

    task automatic test_enable_toggle();
        do_reset();
        for (int i = 0; i < 320; i++) begin
            enable = ((i % 2) == 0);
            tick();
            if (enable) n_en++;
            n_cmp++; if ({early, prompt, late} !== {exp_early(n_en), exp_early(n_en - 8), exp_early(n_en - 16)}) begin
                n_err++; $display("FAIL toggle_epl clk=%0d: got %b expected %b", i, {early, prompt, late}, {exp_early(n_en), exp_early(n_en - 8), exp_early(n_en - 16)});
            end
            n_cmp++; if (chip_idx !== 10'(n_en / 16)) begin n_err++; $display("FAIL toggle_chip_idx clk=%0d: got %0d expected %0d", i, chip_idx, n_en / 16); end
        end
    endtask

    task automatic test_correction();
        do_reset();
        corr_valid = 1'b1; correction = 32'h1000_0000; enable = 1'b1;
        tick();
        corr_valid = 1'b0; correction = 32'd0;
        n_cmp++; if (code_phase !== 32'h1000_0000) begin n_err++; $display("FAIL corr_old_fcw: got %h expected 10000000", code_phase); end
        for (int k = 2; k <= 25; k++) begin
            tick();
            n_cmp++; if (code_phase !== 32'h1000_0000 + 32'(k - 1) * 32'h2000_0000) begin
                n_err++; $display("FAIL corr_phase k=%0d: got %h expected %h", k, code_phase, 32'h1000_0000 + 32'(k - 1) * 32'h2000_0000);
            end
            n_cmp++; if (chip_idx !== 10'((k - 1) / 8)) begin n_err++; $display("FAIL corr_chip_idx k=%0d: got %0d expected %0d", k, chip_idx, (k - 1) / 8); end
        end
    endtask

    task automatic test_clamp();
        // in-range negative correction: fcw = 2^27
        do_reset();
        corr_valid = 1'b1; correction = 32'hF800_0000;
        tick();
        corr_valid = 1'b0; enable = 1'b1;
        tick();
        n_cmp++; if (code_phase !== 32'h0800_0000) begin n_err++; $display("FAIL clamp_mid: got %h expected 08000000", code_phase); end
        // lower clamp
        do_reset();
        corr_valid = 1'b1; correction = 32'h8000_0000;
        tick();
        corr_valid = 1'b0;
        n_cmp++; if (code_phase !== 32'd0) begin n_err++; $display("FAIL clamp_min_hold: got %h expected 0", code_phase); end
        enable = 1'b1;
        tick();
        n_cmp++; if (code_phase !== 32'd1) begin n_err++; $display("FAIL clamp_min_1: got %h expected 1", code_phase); end
        tick();
        n_cmp++; if (code_phase !== 32'd2) begin n_err++; $display("FAIL clamp_min_2: got %h expected 2", code_phase); end
        // upper clamp
        do_reset();
        corr_valid = 1'b1; correction = 32'h7FFF_FFFF;
        tick();
        corr_valid = 1'b0; enable = 1'b1;
        tick();
        n_cmp++; if (code_phase !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL clamp_max_1: got %h expected 7fffffff", code_phase); end
        tick();
        n_cmp++; if ({chip_idx, code_phase} !== {10'd0, 32'hFFFF_FFFE}) begin n_err++; $display("FAIL clamp_max_2: got %0d/%h expected 0/fffffffe", chip_idx, code_phase); end
        tick();
        n_cmp++; if ({chip_idx, code_phase} !== {10'd1, 32'h7FFF_FFFD}) begin n_err++; $display("FAIL clamp_max_3: got %0d/%h expected 1/7ffffffd", chip_idx, code_phase); end
    endtask

    task automatic test_corr_on_carry();
        do_reset();
        for (int k = 1; k <= 15; k++) step_en();
        corr_valid = 1'b1; correction = 32'h1000_0000;
        step_en();
        corr_valid = 1'b0; correction = 32'd0;
        n_cmp++; if ({chip_idx, code_phase} !== {10'd1, 32'h0000_0000}) begin n_err++; $display("FAIL carry_corr_step: got %0d/%h expected 1/00000000", chip_idx, code_phase); end
        step_en();
        n_cmp++; if (code_phase !== 32'h2000_0000) begin n_err++; $display("FAIL carry_corr_next: got %h expected 20000000", code_phase); end
        for (int k = 18; k <= 23; k++) step_en();
        n_cmp++; if ({chip_idx, code_phase} !== {10'd1, 32'hE000_0000}) begin n_err++; $display("FAIL carry_corr_pre: got %0d/%h expected 1/e0000000", chip_idx, code_phase); end
        step_en();
        n_cmp++; if ({chip_idx, code_phase} !== {10'd2, 32'h0000_0000}) begin n_err++; $display("FAIL carry_corr_chip: got %0d/%h expected 2/00000000", chip_idx, code_phase); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        corr_valid = 1'b1; correction = 32'h1000_0000;
        tick();
        corr_valid = 1'b0; correction = 32'd0;
        for (int k = 0; k < 4000; k++) step_en();
        n_cmp++; if ({chip_idx, code_phase} !== {10'd500, 32'd0}) begin n_err++; $display("FAIL mid_pre: got %0d/%h expected 500/00000000", chip_idx, code_phase); end
        rst = 1'b1; enable = 1'b1;
        tick();
        n_cmp++; if ({early, prompt, late, epoch} !== 4'b0000) begin n_err++; $display("FAIL mid_outs: got %b expected 0000", {early, prompt, late, epoch}); end
        n_cmp++; if ({chip_idx, code_phase} !== {10'd0, 32'd0}) begin n_err++; $display("FAIL mid_state: got %0d/%h expected 0/00000000", chip_idx, code_phase); end
        rst = 1'b0;
        n_en = 0;
        for (int i = 0; i < 160; i++) begin
            step_en();
            n_cmp++; if (early !== exp_early(n_en)) begin n_err++; $display("FAIL mid_early n=%0d: got %b expected %b", n_en, early, exp_early(n_en)); end
            n_cmp++; if (chip_idx !== 10'(n_en / 16)) begin n_err++; $display("FAIL mid_chip_idx n=%0d: got %0d expected %0d", n_en, chip_idx, n_en / 16); end
            n_cmp++; if (code_phase !== (32'(n_en) << 28)) begin n_err++; $display("FAIL mid_phase n=%0d: got %h expected %h", n_en, code_phase, 32'(n_en) << 28); end
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; corr_valid = 1'b0; correction = 32'd0;
        test_reset();
        test_prn1(150);
        test_freeze();
        test_epoch();
        test_enable_toggle();
        test_correction();
        test_clamp();
        test_corr_on_carry();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
